// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared state type and default widths for the formula vector sweeper
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    localparam int N_IN_DEF    = 37;
    localparam int SWEEP_W_DEF = 16;

endpackage

// File: rtl/sweep_counter.sv
// rtl/sweep_counter.sv - loadable low-field incrementer with an all-ones flag
module sweep_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic         last_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = &count_q;

endmodule

// File: rtl/formula_vector_sweeper.sv
// rtl/formula_vector_sweeper.sv - drives a combinational formula with swept vectors and checks its output
module formula_vector_sweeper
    import sweep_pkg::*;
#(
    parameter int N_IN    = N_IN_DEF,
    parameter int SWEEP_W = SWEEP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              stop_on_cex,
    input  logic [N_IN-1:0]   base_vec,
    output logic [N_IN-1:0]   f_vec,
    input  logic              f_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              cex_valid,
    output logic              cex_vec_unused_guard,
    output logic [N_IN-1:0]   cex_vec,
    output logic [SWEEP_W:0]  sat_count,
    output logic              aborted
);

    localparam logic [N_IN-1:0] LOW_MASK = N_IN'({SWEEP_W{1'b1}});

    sweep_state_t      state_q;
    logic [N_IN-1:0]   base_hi_q;
    logic              stop_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic              cex_valid_q;
    logic [N_IN-1:0]   cex_vec_q;
    logic [SWEEP_W:0]  sat_q;
    logic              aborted_q;

    logic [SWEEP_W-1:0] low;
    logic               last;
    logic               in_run;
    logic               hit_cex;
    logic               end_run;
    logic               cnt_load;
    logic               cnt_inc;

    assign in_run   = (state_q == RUN);
    // An aborted cycle's vector is neither counted nor captured.
    assign hit_cex  = in_run && !abort && !f_out && !cex_valid_q;
    assign end_run  = in_run && (abort || (hit_cex && stop_q) || last);
    assign cnt_load = (state_q == IDLE) && start;
    assign cnt_inc  = in_run && !end_run;

    sweep_counter #(
        .W (SWEEP_W)
    ) u_counter (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (cnt_load),
        .inc_i   (cnt_inc),
        .count_o (low),
        .last_o  (last)
    );

    // Both terms are registers, so the formula sees a glitch-free vector.
    assign f_vec = base_hi_q | N_IN'(low);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            base_hi_q   <= '0;
            stop_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            cex_valid_q <= 1'b0;
            cex_vec_q   <= '0;
            sat_q       <= '0;
            aborted_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_hi_q   <= base_vec & ~LOW_MASK;
                        stop_q      <= stop_on_cex;
                        busy_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        cex_valid_q <= 1'b0;
                        cex_vec_q   <= '0;
                        sat_q       <= '0;
                        aborted_q   <= 1'b0;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    if (!abort && f_out) begin
                        sat_q <= sat_q + (SWEEP_W+1)'(1);
                    end
                    if (hit_cex) begin
                        cex_valid_q <= 1'b1;
                        cex_vec_q   <= f_vec;
                    end
                    if (abort) begin
                        aborted_q <= 1'b1;
                    end
                    if (end_run) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= !abort && !(cex_valid_q || hit_cex);
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy                 = busy_q;
    assign done                 = done_q;
    assign pass                 = pass_q;
    assign cex_valid            = cex_valid_q;
    assign cex_vec              = cex_vec_q;
    assign sat_count            = sat_q;
    assign aborted              = aborted_q;
    assign cex_vec_unused_guard = 1'b0;

endmodule

// File: tb/tb_formula_vector_sweeper.sv
// tb/tb_formula_vector_sweeper.sv - directed table-driven bench for formula_vector_sweeper
module tb_formula_vector_sweeper;

    localparam int N_IN = 37;
    localparam int SW   = 4;
    localparam logic [N_IN-1:0] MASK_LO = 37'hF;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            stop_on_cex = 1'b0;
    logic [N_IN-1:0] base_vec = '0;
    logic [N_IN-1:0] f_vec;
    logic            f_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic            cex_valid;
    logic            guard;
    logic [N_IN-1:0] cex_vec;
    logic [SW:0]     sat_count;
    logic            aborted;

    int mode = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Formula stub: mode 0 is always true, mode 1 is false only for low field 9.
    assign f_out = (mode == 0) ? 1'b1 : (f_vec[3:0] != 4'd9);

    formula_vector_sweeper #(
        .N_IN    (N_IN),
        .SWEEP_W (SW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .abort                (abort),
        .stop_on_cex          (stop_on_cex),
        .base_vec             (base_vec),
        .f_vec                (f_vec),
        .f_out                (f_out),
        .busy                 (busy),
        .done                 (done),
        .pass                 (pass),
        .cex_valid            (cex_valid),
        .cex_vec_unused_guard (guard),
        .cex_vec              (cex_vec),
        .sat_count            (sat_count),
        .aborted              (aborted)
    );

    typedef struct {
        int              mode;
        logic            stop;
        logic [N_IN-1:0] base;
        int              abort_at;
        int              start_at;
        int              lat;
        int              sat;
        logic            cexv;
        logic [N_IN-1:0] cex;
        logic            pass;
        logic            ab;
        int              last_low;
    } vec_t;

    vec_t rows[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(output int n, output bit got);
        n = 0;
        got = 1'b0;
        while (n < 100 && !got) begin
            @(negedge clk);
            n++;
            if (done) got = 1'b1;
        end
    endtask

    task automatic run_row(input int idx, input vec_t v);
        int n;
        bit got;
        mode        = v.mode;
        stop_on_cex = v.stop;
        base_vec    = v.base;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n   = 0;
        got = 1'b0;
        while (n < 100 && !got) begin
            @(negedge clk);
            n++;
            if (done) begin
                got = 1'b1;
            end else begin
                chk($sformatf("r%0d busy_run", idx), 64'(busy), 64'd1);
                chk($sformatf("r%0d f_vec_low", idx), 64'(f_vec[3:0]), 64'(n - 1));
                chk($sformatf("r%0d f_vec_hi", idx), 64'(f_vec & ~MASK_LO), 64'(v.base & ~MASK_LO));
                abort = (n == v.abort_at);
                start = (n == v.start_at);
            end
        end
        abort = 1'b0;
        start = 1'b0;
        chk($sformatf("r%0d done_seen", idx), 64'(got), 64'd1);
        chk($sformatf("r%0d latency", idx), 64'(n), 64'(v.lat));
        chk($sformatf("r%0d busy_done", idx), 64'(busy), 64'd0);
        chk($sformatf("r%0d sat_count", idx), 64'(sat_count), 64'(v.sat));
        chk($sformatf("r%0d cex_valid", idx), 64'(cex_valid), 64'(v.cexv));
        chk($sformatf("r%0d cex_vec", idx), 64'(cex_vec), 64'(v.cex));
        chk($sformatf("r%0d pass", idx), 64'(pass), 64'(v.pass));
        chk($sformatf("r%0d aborted", idx), 64'(aborted), 64'(v.ab));
        chk($sformatf("r%0d f_vec_last", idx), 64'(f_vec),
            64'((v.base & ~MASK_LO) | 37'(v.last_low)));
        @(negedge clk);
        chk($sformatf("r%0d done_pulse", idx), 64'(done), 64'd0);
        chk($sformatf("r%0d pass_hold", idx), 64'(pass), 64'(v.pass));
        chk($sformatf("r%0d sat_hold", idx), 64'(sat_count), 64'(v.sat));
    endtask

    initial begin
        int n;
        bit got;

        rows[0] = '{mode:0, stop:1'b0, base:37'h0, abort_at:0, start_at:0,
                    lat:17, sat:16, cexv:1'b0, cex:37'h0, pass:1'b1, ab:1'b0, last_low:15};
        rows[1] = '{mode:1, stop:1'b1, base:37'h0, abort_at:0, start_at:0,
                    lat:11, sat:9, cexv:1'b1, cex:37'h9, pass:1'b0, ab:1'b0, last_low:9};
        rows[2] = '{mode:1, stop:1'b0, base:37'h0, abort_at:0, start_at:0,
                    lat:17, sat:15, cexv:1'b1, cex:37'h9, pass:1'b0, ab:1'b0, last_low:15};
        rows[3] = '{mode:0, stop:1'b0, base:37'h0, abort_at:5, start_at:0,
                    lat:6, sat:4, cexv:1'b0, cex:37'h0, pass:1'b0, ab:1'b1, last_low:4};
        rows[4] = '{mode:0, stop:1'b0, base:37'h1F_FFFF_FFF0, abort_at:0, start_at:3,
                    lat:17, sat:16, cexv:1'b0, cex:37'h0, pass:1'b1, ab:1'b0, last_low:15};
        rows[5] = '{mode:1, stop:1'b1, base:37'h15_5555_5555, abort_at:0, start_at:0,
                    lat:11, sat:9, cexv:1'b1, cex:37'h15_5555_5559, pass:1'b0, ab:1'b0, last_low:9};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst f_vec", 64'(f_vec), 64'd0);
        chk("rst cex_vec", 64'(cex_vec), 64'd0);
        chk("rst sat_count", 64'(sat_count), 64'd0);
        chk("rst flags", 64'({busy, done, pass, cex_valid, aborted}), 64'd0);

        for (int i = 0; i < 6; i++) begin
            run_row(i, rows[i]);
        end

        // start coinciding with done is ignored; accepted in the following IDLE cycle
        mode        = 0;
        stop_on_cex = 1'b0;
        base_vec    = '0;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(n, got);
        chk("seq1 done_seen", 64'(got), 64'd1);
        start = 1'b1;
        @(negedge clk);
        chk("seq1 busy_after_done", 64'(busy), 64'd0);
        @(negedge clk);
        chk("seq1 busy_restart", 64'(busy), 64'd1);
        start = 1'b0;
        wait_done(n, got);
        chk("seq1 done2_seen", 64'(got), 64'd1);
        chk("seq1 latency2", 64'(n), 64'd16);
        chk("seq1 sat2", 64'(sat_count), 64'd16);
        @(negedge clk);

        // asynchronous reset in the middle of a sweep
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        chk("seq2 busy_pre", 64'(busy), 64'd1);
        chk("seq2 sat_pre", 64'(sat_count), 64'd4);
        #1 rst = 1'b1;
        #1;
        chk("seq2 async_f_vec", 64'(f_vec), 64'd0);
        chk("seq2 async_sat", 64'(sat_count), 64'd0);
        chk("seq2 async_flags", 64'({busy, done, pass, cex_valid, aborted}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk("seq2 no_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        run_row(6, rows[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/formula_vector_sweeper.md
# formula_vector_sweeper

Sequential driver and result checker for a combinational synthesized-formula block with a 37-bit input vector and a single-bit output. It enumerates the low `SWEEP_W` input bits while holding the upper bits at a latched base value, and applies one vector per cycle to the formula. It samples the formula output, counts satisfying vectors, and captures the first falsifying vector as a counterexample. It sits directly upstream of the formula block: it drives the formula's inputs and consumes its `o_1`.

## Interface
- `N_IN`, 37: formula input width.
- `SWEEP_W`, 16: number of low bits enumerated (1..N_IN); the sweep covers 2^SWEEP_W vectors.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: begin a sweep; accepted only in IDLE.
- `abort`  in  1: stop a running sweep.
- `stop_on_cex`  in  1: 1 = end the sweep at the first falsifying vector; 0 = sweep fully. Latched at start.
- `base_vec`  in  N_IN: supplies the upper bits [N_IN-1:SWEEP_W]. Latched at start.
- `f_vec`  out  N_IN: registered vector to the formula inputs (bit 0 = v_1).
- `f_out`  in  1: formula output (o_1), combinational from `f_vec`.
- `busy`  out  1: high in RUN.
- `done`  out  1: one-cycle pulse at the end of a sweep.
- `pass`  out  1: valid with `done` and held afterwards; 1 iff no falsifying vector was seen and the sweep was not aborted.
- `cex_valid`  out  1: a falsifying vector was captured.
- `cex_vec`  out  N_IN: first falsifying vector.
- `sat_count`  out  SWEEP_W+1: number of evaluated vectors with `f_out`=1.
- `aborted`  out  1: the last sweep ended by `abort`.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - On `start`:
    - latch `base_vec` and `stop_on_cex`;
    - load `f_vec` = {base_vec[N_IN-1:SWEEP_W], SWEEP_W'0};
    - clear `sat_count`, `cex_valid`, `cex_vec`, `pass`, `aborted`;
    - go to RUN.
- **RUN** (each cycle the current `f_vec` is evaluated)
  - `f_out`=1: `sat_count`++.
  - `f_out`=0 and `cex_valid`=0: set `cex_valid`, `cex_vec` = `f_vec`.
  - Go to DONE if:
    - `abort` (the current vector is not counted; set `aborted`); or
    - the falsifying vector is seen with `stop_on_cex`=1; or
    - the low field is all ones.
  - Otherwise the low field increments by one; the upper bits never change.
- **DONE**
  - Assert `done` for one cycle.
  - `pass` = ~`cex_valid` & ~`aborted`.
  - Go to IDLE.
- `start` is ignored outside IDLE. `abort` is ignored outside RUN.
- Results hold until the next accepted `start`.
- Wrap-around: the low field never wraps during a sweep, because the all-ones vector ends the sweep. `sat_count` is one bit wider than the sweep field, so it reaches 2^SWEEP_W without overflow.

## Timing
- Reset values:
  - state IDLE;
  - `f_vec`, `cex_vec` = 0;
  - `sat_count` = 0;
  - `busy`, `done`, `pass`, `cex_valid`, `aborted` = 0.
- Reset mid-sweep returns immediately to these values; no `done` is produced.
- `start` is sampled at edge k. RUN holds for cycles k+1 .. k+2^SWEEP_W on a full sweep. `done` is high in cycle k+2^SWEEP_W+1.
- A falsifying vector at index i with `stop_on_cex`=1 puts `done` in cycle k+i+2.
- `abort` is sampled in RUN at cycle j; `done` is high in cycle j+1.
- The formula path is combinational: `f_vec` register → formula → `f_out` → capture registers, one cycle.
- `start` asserted in the same cycle as `done` is ignored (state is DONE); it is accepted in the following IDLE cycle.

## Structure
- Package `sweep_pkg`:
  - `sweep_state_t` enum {IDLE, RUN, DONE};
  - localparam defaults for N_IN and SWEEP_W.
- Sub-module `sweep_counter`: SWEEP_W-bit loadable incrementer with a `last` flag (all ones). The top level holds the FSM and capture logic.

## Test plan
- SWEEP_W=4, formula stub `f_out`=1: start → 16 RUN cycles, `done` at start+17, `pass`=1, `sat_count`=16, `cex_valid`=0.
- SWEEP_W=4, stub `f_out` = ~(low==4'd9), `stop_on_cex`=1: `cex_vec` low=9, `sat_count`=9, `done` at start+11, `pass`=0.
- Same stub, `stop_on_cex`=0: full 16 cycles, `sat_count`=15, `cex_vec` low=9, `pass`=0.
- `abort` at the 5th RUN cycle: `done` the next cycle, `aborted`=1, `pass`=0, `sat_count`=4.
- `base_vec`=37'h1F_FFFF_FFF0: every `f_vec` has upper bits = base_vec[36:4]; a `start` pulse during RUN is ignored.
- `rst` mid-sweep: all outputs return to 0 asynchronously; no `done`; a new `start` works normally.
